// File: rtl/simd_mac_sequencer.sv
// Burst controller for the 4-lane int8 SIMD dot-product datapath: buffers operand
// words written by the CPU, streams them into the datapath and returns one accumulated sum.
module simd_mac_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        mac_valid,
  output logic [31:0] mac_op_a,
  output logic [31:0] mac_op_b,
  input  logic [31:0] mac_sum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_WR_A   = 3'd0;
  localparam logic [2:0] OP_WR_B   = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_RD_ACC = 3'd3;
  localparam logic [2:0] OP_CLR    = 3'd4;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

  logic [1:0]         state;
  logic [31:0]        buf_a [DEPTH];
  logic [31:0]        buf_b [DEPTH];
  logic [ADDR_W-1:0]  step;
  logic [ADDR_W-1:0]  last;
  logic signed [31:0] acc;
  logic signed [31:0] sum_s;
  logic signed [31:0] acc_next;

  logic               accept;
  logic               legal;
  logic [2:0]         opc;
  logic [CNT_W-1:0]   run_n;
  logic [ADDR_W-1:0]  wr_idx;

  function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return a + b;
  endfunction

  assign cmd_ready = (state == S_IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign opc       = cmd_payload_function_id[2:0];
  assign legal     = (cmd_payload_function_id[9:3] == 7'd0);
  assign wr_idx    = cmd_payload_inputs_0[ADDR_W-1:0];
  assign sum_s     = $signed(mac_sum);
  assign acc_next  = wrap_add(acc, sum_s);

  // Oversized counts saturate on the whole operand so any large request runs the full buffer.
  always_comb begin
    run_n = cmd_payload_inputs_0[CNT_W-1:0];
    if (cmd_payload_inputs_0 >= 32'(DEPTH)) run_n = DEPTH_N;
  end

  assign mac_valid = (state == S_RUN);
  assign mac_op_a  = mac_valid ? buf_a[step] : 32'd0;
  assign mac_op_b  = mac_valid ? buf_b[step] : 32'd0;

  // Operand storage is data only; it keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (accept && legal && opc == OP_WR_A) buf_a[wr_idx] <= cmd_payload_inputs_1;
    if (accept && legal && opc == OP_WR_B) buf_b[wr_idx] <= cmd_payload_inputs_1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_IDLE;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= 32'd0;
      acc                   <= 32'sd0;
      step                  <= '0;
      last                  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (legal && opc == OP_RUN) begin
              step <= '0;
              last <= run_n[ADDR_W-1:0] - 1'b1;
              if (cmd_payload_inputs_1[0]) acc <= 32'sd0;
              if (run_n == '0) begin
                state                 <= S_RESP;
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= cmd_payload_inputs_1[0] ? 32'd0 : acc;
              end else begin
                state <= S_RUN;
              end
            end else begin
              rsp_valid             <= 1'b1;
              rsp_payload_outputs_0 <= (legal && opc == OP_RD_ACC) ? acc : 32'd0;
              if (legal && opc == OP_CLR) acc <= 32'sd0;
            end
          end
        end
        S_RUN: begin
          acc  <= acc_next;
          step <= step + 1'b1;
          if (step == last) begin
            state                 <= S_RESP;
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= acc_next;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_mac_sequencer.sv
// Directed bench for simd_mac_sequencer with a behavioural offset-128 x signed dot-product datapath.
module tb_simd_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        mac_valid;
  logic [31:0] mac_op_a;
  logic [31:0] mac_op_b;
  logic [31:0] mac_sum;

  int checks = 0;
  int errors = 0;

  simd_mac_sequencer #(.DEPTH(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .mac_valid               (mac_valid),
    .mac_op_a                (mac_op_a),
    .mac_op_b                (mac_op_b),
    .mac_sum                 (mac_sum)
  );

  always #5 clk = ~clk;

  // Datapath model: sum over lanes of (a - 128) * signed(b).
  always_comb begin
    mac_sum = 32'd0;
    for (int l = 0; l < 4; l++)
      mac_sum = mac_sum + 32'($signed({1'b0, mac_op_a[8*l +: 8]}) - 128) *
                          32'($signed(mac_op_b[8*l +: 8]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [9:0] fid,
                       input logic [31:0] a0, input logic [31:0] a1);
    int w;
    cmd_valid               = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = a0;
    cmd_payload_inputs_1    = a1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk({tag, "_accept_timeout"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output int macs);
    lat  = 1;
    macs = 0;
    while (!rsp_valid && lat < 200) begin
      if (mac_valid) macs++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic [9:0] fid, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [31:0] exp_data,
                      input int exp_lat, input int exp_macs);
    int lat, macs;
    issue(tag, fid, a0, a1);
    collect(lat, macs);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_payload_outputs_0, exp_data);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_mac_cycles"}, macs, exp_macs);
    take_rsp();
    chk({tag, "_rsp_clear"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] op, input int idx, input logic [31:0] data);
    int lat, macs;
    issue("wr", {7'd0, op}, idx, data);
    collect(lat, macs);
    take_rsp();
  endtask

  initial begin
    int lat, macs;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_payload_function_id = 10'd0; cmd_payload_inputs_0 = 32'd0; cmd_payload_inputs_1 = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    chk("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
    chk("rst_op_a", mac_op_a, 32'd0);
    chk("rst_op_b", mac_op_b, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Offset cancels: (0x80-128)*1 = 0 per lane
    xact("wr_a0", 10'd0, 0, 32'h8080_8080, 32'd0, 1, 0);
    xact("wr_b0", 10'd1, 0, 32'h0101_0101, 32'd0, 1, 0);
    xact("run1", 10'd2, 1, 32'd1, 32'd0, 2, 1);

    // 1*2*4 lanes = 8 per word
    for (int i = 0; i < 16; i++) begin
      wr(3'd0, i, 32'h8181_8181);
      wr(3'd1, i, 32'h0202_0202);
    end
    xact("run4", 10'd2, 4, 32'd1, 32'd32, 5, 4);
    xact("run4_noclr", 10'd2, 4, 32'd0, 32'd64, 5, 4);
    xact("rd_acc64", 10'd3, 0, 32'd0, 32'd64, 1, 0);
    xact("run0", 10'd2, 0, 32'd1, 32'd0, 1, 0);

    // Word 5: (-1)*3*4 = -12; 15*8 - 12 = 108
    wr(3'd0, 5, 32'h7F7F_7F7F);
    wr(3'd1, 5, 32'h0303_0303);
    xact("run100", 10'd2, 100, 32'd1, 32'd108, 17, 16);

    // Index 17 wraps to 1: (4)*2*4 = 32; 8 + 32 = 40
    wr(3'd0, 17, 32'h8484_8484);
    xact("run2_wrap", 10'd2, 2, 32'd1, 32'd40, 3, 2);

    // Response held with rsp_ready low; pending CLR must not be accepted
    issue("hold_run", 10'd2, 1, 32'd1);
    collect(lat, macs);
    cmd_valid = 1'b1; cmd_payload_function_id = 10'd4;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_payload_outputs_0, 32'd8);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    take_rsp();
    xact("rd_after_hold", 10'd3, 0, 32'd0, 32'd8, 1, 0);

    // Reset during step 2 of an N=8 burst
    issue("rst_run", 10'd2, 8, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_mac_valid", {31'd0, mac_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_mac_valid", {31'd0, mac_valid}, 32'd0);
    chk("abort_op_a", mac_op_a, 32'd0);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    xact("rd_after_abort", 10'd3, 0, 32'd0, 32'd0, 1, 0);

    // Illegal function_id and reserved opcode are NOPs
    xact("set_acc8", 10'd2, 1, 32'd1, 32'd8, 2, 1);
    xact("nop_hibit", 10'h008, 0, 32'h0000_0055, 32'd0, 1, 0);
    xact("nop_op5", 10'd5, 0, 32'd0, 32'd0, 1, 0);
    xact("rd_after_nop", 10'd3, 0, 32'd0, 32'd8, 1, 0);
    xact("buf_after_nop", 10'd2, 1, 32'd1, 32'd8, 2, 1);
    xact("clr", 10'd4, 0, 32'd0, 32'd0, 1, 0);
    xact("rd_after_clr", 10'd3, 0, 32'd0, 32'd0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
